// File: rtl/rand_matrix_filler_pkg.sv
// rand_matrix_filler shared package
// FSM encoding, sizes and the linear address helper
package rand_matrix_filler_pkg;

  localparam int MAX_DIM   = 5;
  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 5;
  localparam int RETRY_MAX = 8;
  localparam int DIM_W     = 3;
  localparam int RTRY_W    = $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_SAMPLE,
    S_WRITE,
    S_FIN
  } state_e;

  function automatic logic [ADDR_W-1:0] lin_addr(
    input logic [DIM_W-1:0] r,
    input logic [DIM_W-1:0] c
  );
    return ADDR_W'(r) * ADDR_W'(MAX_DIM) + ADDR_W'(c);
  endfunction

endpackage

// File: rtl/rand_matrix_filler_if.sv
// rand_matrix_filler element write port
// valid/ready bundle towards matrix storage
interface rand_matrix_filler_if;
  import rand_matrix_filler_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DIM_W-1:0]  wr_row;
  logic [DIM_W-1:0]  wr_col;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_row,
    output wr_col,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_row,
    input  wr_col,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/rand_matrix_filler_range_sampler.sv
// range_sampler: accept check, retry count, fallback
// take_o says the current nibble (or the fallback) becomes the element
module range_sampler
  import rand_matrix_filler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] rnd_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] hi_i,
  output logic              take_o,
  output logic [DATA_W-1:0] data_o
);

  logic              accept;
  logic [RTRY_W-1:0] retry_q;
  logic [RTRY_W-1:0] retry_d;

  assign accept  = (rnd_i >= lo_i) && (rnd_i <= hi_i);
  assign retry_d = retry_q + RTRY_W'(1);
  assign take_o  = accept |
                   (retry_d == RTRY_W'(RETRY_MAX));
  assign data_o  = accept ? rnd_i : lo_i;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      retry_q <= '0;
    end else if (en_i && !accept) begin
      retry_q <= retry_d;
    end
  end

endmodule

// File: rtl/rand_matrix_filler.sv
// rand_matrix_filler: random matrix fill FSM
// draws nibbles, rejects out-of-range, writes row-major
module rand_matrix_filler
  import rand_matrix_filler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  rows_i,
  input  logic [DIM_W-1:0]  cols_i,
  input  logic [DATA_W-1:0] val_lo_i,
  input  logic [DATA_W-1:0] val_hi_i,
  input  logic [DATA_W-1:0] rnd_i,
  output logic              rnd_req_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  rand_matrix_filler_if.master wr
);

  state_e            state_q;
  logic [DIM_W-1:0]  rows_q, cols_q;
  logic [DATA_W-1:0] lo_q, hi_q;
  logic [DIM_W-1:0]  row_q, col_q;
  logic [DIM_W-1:0]  row_d, col_d;
  logic              rnd_req_q, busy_q;
  logic              done_q, err_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DIM_W-1:0]  wr_row_q, wr_col_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              cfg_ok;
  logic              hs;
  logic              last_el;
  logic              smp_take;
  logic [DATA_W-1:0] smp_data;

  assign cfg_ok =
    (rows_i != '0) &&
    (rows_i <= DIM_W'(MAX_DIM)) &&
    (cols_i != '0) &&
    (cols_i <= DIM_W'(MAX_DIM)) &&
    (val_lo_i <= val_hi_i);

  assign hs      = wr_valid_q & wr.wr_ready;
  assign last_el = (row_q == rows_q - 3'd1) &&
                   (col_q == cols_q - 3'd1);

  always_comb begin
    row_d = row_q;
    col_d = col_q + 3'd1;
    if (col_q == cols_q - 3'd1) begin
      col_d = '0;
      row_d = row_q + 3'd1;
    end
  end

  range_sampler u_smp (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (hs || (state_q == S_IDLE)),
    .en_i   (state_q == S_SAMPLE),
    .rnd_i  (rnd_i),
    .lo_i   (lo_q),
    .hi_i   (hi_q),
    .take_o (smp_take),
    .data_o (smp_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rnd_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      rnd_req_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rows_q <= rows_i;
            cols_q <= cols_i;
            lo_q   <= val_lo_i;
            hi_q   <= val_hi_i;
            if (cfg_ok) begin
              state_q   <= S_DRAW;
              rnd_req_q <= 1'b1;
              busy_q    <= 1'b1;
              row_q     <= '0;
              col_q     <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_DRAW: begin
          state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (smp_take) begin
            state_q    <= S_WRITE;
            wr_valid_q <= 1'b1;
            wr_data_q  <= smp_data;
            wr_addr_q  <= lin_addr(row_q, col_q);
            wr_row_q   <= row_q;
            wr_col_q   <= col_q;
          end else begin
            state_q   <= S_DRAW;
            rnd_req_q <= 1'b1;
          end
        end
        S_WRITE: begin
          if (hs) begin
            wr_valid_q <= 1'b0;
            row_q      <= row_d;
            col_q      <= col_d;
            if (last_el) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_DRAW;
              rnd_req_q <= 1'b1;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rnd_req_o   = rnd_req_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_row   = wr_row_q;
  assign wr.wr_col   = wr_col_q;
  assign wr.wr_data  = wr_data_q;

endmodule

// File: tb/tb_rand_matrix_filler.sv
// tb_rand_matrix_filler: scoreboard bench
// nibble-stream model predicts each write; monitor compares
`timescale 1ns/1ps
module tb_rand_matrix_filler;
  import rand_matrix_filler_pkg::*;

  typedef struct {
    int addr;
    int row;
    int col;
    int data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [2:0] rows_i = '0;
  logic [2:0] cols_i = '0;
  logic [3:0] val_lo_i = '0;
  logic [3:0] val_hi_i = '0;
  logic [3:0] rnd_i = '0;
  logic       rnd_req_o, busy_o, done_o, err_o;
  logic       ready_man = 1'b1;
  logic       ready_rr = 1'b0;
  logic       ready_rand = 1'b0;

  rand_matrix_filler_if wr_if();
  assign wr_if.wr_ready = ready_rand ? ready_rr : ready_man;

  rand_matrix_filler dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .rows_i   (rows_i),
    .cols_i   (cols_i),
    .val_lo_i (val_lo_i),
    .val_hi_i (val_hi_i),
    .rnd_i    (rnd_i),
    .rnd_req_o(rnd_req_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .wr       (wr_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  int dq[$];
  int addr_log[$];
  int m_rows, m_cols, m_lo, m_hi, m_idx, m_rej;
  int n_req = 0, n_done = 0, n_err = 0;
  int n_hs = 0, n_stall = 0;
  int first_req = -1, done_cyc = 0;
  int req0, hs0, done0, stall0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) ready_rr = 1'($urandom_range(0, 1));

  // reference: the nth accepted (or fallback) value is element n, row-major
  always @(negedge clk) begin
    if (!rst && rnd_req_o) begin
      int v;
      exp_t e;
      v = (dq.size() > 0) ? dq.pop_front()
                          : int'($urandom_range(0, 15));
      rnd_i = 4'(v);
      if (v >= m_lo && v <= m_hi) begin
        m_rej = 0;
      end else begin
        m_rej++;
        v = m_lo;
      end
      if (m_rej == 0 || m_rej == RETRY_MAX) begin
        e.row  = m_idx / m_cols;
        e.col  = m_idx % m_cols;
        e.addr = e.row * MAX_DIM + e.col;
        e.data = v;
        exp_q.push_back(e);
        m_idx++;
        m_rej = 0;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rnd_req_o) begin
      n_req++;
      if (first_req < 0) first_req = cyc;
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err_o) n_err++;
    if (wr_if.wr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else if (wr_if.wr_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(wr_if.wr_addr), e.addr);
        chk("wr_row", int'(wr_if.wr_row), e.row);
        chk("wr_col", int'(wr_if.wr_col), e.col);
        chk("wr_data", int'(wr_if.wr_data), e.data);
        addr_log.push_back(int'(wr_if.wr_addr));
        n_hs++;
      end else begin
        n_stall++;
        chk("stall_addr", int'(wr_if.wr_addr), exp_q[0].addr);
        chk("stall_data", int'(wr_if.wr_data), exp_q[0].data);
      end
    end
  end

  task automatic start_fill(int r, int c, int lo, int hi);
    @(negedge clk);
    m_rows = r; m_cols = c; m_lo = lo; m_hi = hi;
    m_idx = 0; m_rej = 0;
    req0 = n_req; hs0 = n_hs; done0 = n_done;
    stall0 = n_stall; first_req = -1;
    addr_log.delete();
    rows_i = 3'(r); cols_i = 3'(c);
    val_lo_i = 4'(lo); val_hi_i = 4'(hi);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", int'(busy_o), 1);
    chk("no_err_legal", int'(err_o), 0);
  endtask

  task automatic wait_done(int tmo, int n_el);
    int k;
    k = 0;
    while (n_done == done0 && k < tmo) begin
      @(negedge clk);
      k++;
    end
    chk("fill_in_time", int'(n_done != done0), 1);
    chk("hs_count", n_hs - hs0, n_el);
    chk("exp_drained", exp_q.size(), 0);
    chk("idle_after_fin", int'(busy_o), 0);
    chk("done_one_cycle", int'(done_o), 0);
  endtask

  task automatic run_fill(int r, int c, int lo, int hi);
    start_fill(r, c, lo, hi);
    wait_done(5000, r * c);
  endtask

  task automatic try_illegal(int r, int c, int lo, int hi);
    @(negedge clk);
    req0 = n_req; hs0 = n_hs;
    rows_i = 3'(r); cols_i = 3'(c);
    val_lo_i = 4'(lo); val_hi_i = 4'(hi);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("illegal_err", int'(err_o), 1);
    chk("illegal_busy", int'(busy_o), 0);
    @(negedge clk);
    chk("illegal_err_once", int'(err_o), 0);
    repeat (3) @(negedge clk);
    chk("illegal_no_req", n_req - req0, 0);
    chk("illegal_no_wr", n_hs - hs0, 0);
    chk("illegal_still_idle", int'(busy_o), 0);
  endtask

  initial begin
    int k;
    int exp_addr[6];
    exp_addr = '{0, 1, 2, 5, 6, 7};
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_req", int'(rnd_req_o), 0);
    chk("rst_valid", int'(wr_if.wr_valid), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    rst = 1'b0;

    // 2x3 full-range fill
    run_fill(2, 3, 0, 15);
    chk("t1_latency", done_cyc - first_req + 1, 19);
    chk("t1_draws", n_req - req0, 6);
    chk("t1_log_len", addr_log.size(), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++)
      chk("t1_addr_order", addr_log[i], exp_addr[i]);

    // rejects before an accept
    dq = '{9, 12, 4};
    run_fill(1, 1, 3, 5);
    chk("t2_draws", n_req - req0, 3);

    // fallback then retry counter restarts
    dq.delete();
    for (int i = 0; i < 15; i++) dq.push_back(0);
    dq.push_back(7);
    run_fill(1, 2, 7, 7);
    chk("t3_draws", n_req - req0, 16);

    try_illegal(0, 3, 0, 15);
    try_illegal(2, 6, 0, 15);
    try_illegal(2, 2, 9, 2);

    // back-pressure and start while busy
    ready_man = 1'b0;
    start_fill(1, 2, 0, 15);
    k = 0;
    while (!wr_if.wr_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5_valid_seen", int'(wr_if.wr_valid), 1);
    rows_i = 3'd1; cols_i = 3'd1;
    val_lo_i = 4'd0; val_hi_i = 4'd0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    ready_man = 1'b1;
    wait_done(200, 2);
    chk("t5_stall_cycles", n_stall - stall0, 4);
    chk("t5_no_err", n_err, 3);

    // reset in SAMPLE of element 3
    start_fill(5, 5, 0, 15);
    k = 0;
    while (!(rnd_req_o && (n_hs - hs0) == 2) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_el3", int'(rnd_req_o), 1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    dq.delete();
    @(negedge clk);
    chk("t6_busy", int'(busy_o), 0);
    chk("t6_req", int'(rnd_req_o), 0);
    chk("t6_valid", int'(wr_if.wr_valid), 0);
    chk("t6_addr", int'(wr_if.wr_addr), 0);
    chk("t6_data", int'(wr_if.wr_data), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_no_done", n_done - done0, 0);
    run_fill(2, 2, 0, 15);
    chk("t6_refill_addr0", addr_log.size() > 0 ? addr_log[0] : -1, 0);

    // randomized fills with random back-pressure
    ready_rand = 1'b1;
    for (int t = 0; t < 8; t++) begin
      int lo, hi;
      lo = int'($urandom_range(0, 15));
      hi = int'($urandom_range(lo, 15));
      run_fill(int'($urandom_range(1, 5)),
               int'($urandom_range(1, 5)), lo, hi);
    end
    ready_rand = 1'b0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
